// File: rtl/aurora_tx_arbiter_if.sv
// ============================================================================
// Module   : aurora_tx_arbiter_if
// Brief    : AXI-Stream bundle (tvalid/tready/tdata/tlast) with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aurora_tx_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input  tready);
   modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/aurora_tx_arbiter.sv
// ============================================================================
// Module   : aurora_tx_arbiter
// Brief    : Frame-locked round-robin arbiter of two AXI-Stream requesters onto
//            the Aurora TX slave port, with max frame length and inter-frame gap.
//            Optional per-requester frame counters: AURORA_TX_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_tx_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 64,
   parameter int GAP_CYCLES = 4
) (
   input  logic                user_clk,
   input  logic                sys_reset_n,
   input  logic                channel_up,
   aurora_tx_arbiter_if.slave  s0_axis,
   aurora_tx_arbiter_if.slave  s1_axis,
   aurora_tx_arbiter_if.master m_axis,
   output logic [1:0]          grant,
   output logic [15:0]         drop_count,
   output logic                oversize_err
`ifdef AURORA_TX_ARB_STATS_EN
   ,
   output logic [31:0]         frame_count0,
   output logic [31:0]         frame_count1
`endif
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_xfer  = 2'd1;
   localparam logic [1:0] c_flush = 2'd2;
   localparam logic [1:0] c_gap   = 2'd3;

   localparam logic [7:0] c_max_last = 8'(MAX_WORDS - 1);
   localparam logic [3:0] c_gap_last = 4'(GAP_CYCLES - 1);
   localparam logic [1:0] c_after    = (GAP_CYCLES == 0) ? c_idle : c_gap;

   logic [1:0]  r_state;
   logic        r_owner;
   logic        r_last;
   logic [7:0]  r_word_cnt;
   logic [3:0]  r_gap_cnt;
   logic [15:0] r_drop;
   logic        r_oversize;

   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_tdata;
   logic                  w_sel_ready;
   logic                  w_in_xfer;
   logic                  w_in_flush;
   logic                  w_pick;
   logic                  w_start;
   logic                  w_at_limit;
   logic                  w_hs;
   logic                  w_end_ok;
   logic                  w_trunc;
   logic                  w_flush_acc;

   assign w_sel_valid = r_owner ? s1_axis.tvalid : s0_axis.tvalid;
   assign w_sel_last  = r_owner ? s1_axis.tlast  : s0_axis.tlast;
   assign w_sel_tdata = r_owner ? s1_axis.tdata  : s0_axis.tdata;

   assign w_in_xfer  = (r_state == c_xfer);
   assign w_in_flush = (r_state == c_flush);

   // Both requesting: serve the one not served last; otherwise the lone requester.
   assign w_pick  = (s0_axis.tvalid && s1_axis.tvalid) ? ~r_last : s1_axis.tvalid;
   assign w_start = (r_state == c_idle) && channel_up && (s0_axis.tvalid || s1_axis.tvalid);

   assign w_at_limit  = (r_word_cnt == c_max_last);
   assign w_hs        = w_in_xfer && w_sel_valid && m_axis.tready;
   assign w_end_ok    = w_hs && w_sel_last;
   assign w_trunc     = w_hs && !w_sel_last && w_at_limit;
   assign w_flush_acc = w_in_flush && w_sel_valid;

   always_comb begin
      w_sel_ready     = w_in_xfer ? m_axis.tready : w_in_flush;
      m_axis.tvalid   = w_in_xfer && w_sel_valid;
      m_axis.tdata    = w_sel_tdata;
      m_axis.tlast    = w_in_xfer && (w_sel_last || w_at_limit);
      s0_axis.tready  = !r_owner && w_sel_ready;
      s1_axis.tready  = r_owner && w_sel_ready;
      grant           = (w_in_xfer || w_in_flush) ? {r_owner, ~r_owner} : 2'b00;
   end

   assign drop_count   = r_drop;
   assign oversize_err = r_oversize;

   always_ff @(posedge user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_state    <= c_idle;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_word_cnt <= 8'd0;
         r_gap_cnt  <= 4'd0;
         r_drop     <= 16'd0;
         r_oversize <= 1'b0;
      end else begin
         r_oversize <= w_trunc;
         case (r_state)
            c_idle: begin
               if (w_start) begin
                  r_owner    <= w_pick;
                  r_word_cnt <= 8'd0;
                  r_state    <= c_xfer;
               end
            end
            c_xfer: begin
               if (w_hs) begin
                  r_word_cnt <= r_word_cnt + 8'd1;
               end
               // Any way the frame leaves XFER counts as served, so contention keeps alternating.
               if (w_end_ok) begin
                  r_last    <= r_owner;
                  r_gap_cnt <= 4'd0;
                  r_state   <= c_after;
               end else if (w_trunc || !channel_up) begin
                  r_last    <= r_owner;
                  r_state   <= c_flush;
               end
            end
            c_flush: begin
               if (w_flush_acc && (r_drop != 16'hFFFF)) begin
                  r_drop <= r_drop + 16'd1;
               end
               if (w_flush_acc && w_sel_last) begin
                  r_gap_cnt <= 4'd0;
                  r_state   <= c_after;
               end
            end
            c_gap: begin
               if (r_gap_cnt == c_gap_last) begin
                  r_state <= c_idle;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

`ifdef AURORA_TX_ARB_STATS_EN
   logic [31:0] r_frames0;
   logic [31:0] r_frames1;
   logic        w_frame_done;

   assign w_frame_done = w_end_ok || w_trunc;
   assign frame_count0 = r_frames0;
   assign frame_count1 = r_frames1;

   always_ff @(posedge user_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_frames0 <= 32'd0;
         r_frames1 <= 32'd0;
      end else if (w_frame_done) begin
         if (r_owner) begin
            r_frames1 <= r_frames1 + 32'd1;
         end else begin
            r_frames0 <= r_frames0 + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire
